// File: rtl/cline_responder_pkg.sv
// ---------------------------------------------------------------------------
// cline_responder_pkg
// Shared types for the L1<->L2 line responder: the LC-3b word and cacheline
// types, the beat index type and the responder FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package cline_responder_pkg;

    localparam int LINE_WORDS = 8;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [2:0]   lc3b_beat;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        BEAT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/cline_beat_buffer.sv
// ---------------------------------------------------------------------------
// cline_beat_buffer
// 128-bit line register that can be loaded either as a whole line or one
// 16-bit word at a time. Whole-line load has priority over word load.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the line)
//   line_we    : load line_in into the whole register
//   line_in    : full line to load
//   word_we    : load word_in into the word selected by word_sel
//   word_sel   : word index, word 0 at bits [15:0]
//   word_in    : word to load
//   line_out   : current register contents
// ---------------------------------------------------------------------------
module cline_beat_buffer
    import cline_responder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          line_we,
    input  lc3b_cacheline line_in,
    input  logic          word_we,
    input  lc3b_beat      word_sel,
    input  lc3b_word      word_in,
    output lc3b_cacheline line_out
);

    lc3b_cacheline data;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (line_we) begin
            data <= line_in;
        end else if (word_we) begin
            data[{word_sel, 4'b0000} +: 16] <= word_in;
        end
    end

    assign line_out = data;

endmodule

// File: rtl/cline_responder.sv
// ---------------------------------------------------------------------------
// cline_responder
// Responder end of the L1<->L2 line interface. Takes one 128-bit line read
// or write from L1 and services it as eight 16-bit beats on the word-wide
// memory bus, then pulses l2_resp for one cycle (with the line on reads).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   l2_read, l2_write     : line request from L1, held until l2_resp
//   l2_address, l2_wdata  : line address / write line, valid one cycle
//                           after the request first rises
//   l2_rdata, l2_resp     : assembled read line, completion pulse
//   mem_read, mem_write   : word strobes, high across all beats
//   mem_address           : word address (always even)
//   mem_wdata             : write word
//   mem_rdata, mem_resp   : read word, beat completion
// ---------------------------------------------------------------------------
module cline_responder
    import cline_responder_pkg::lc3b_word;
    import cline_responder_pkg::lc3b_cacheline;
    import cline_responder_pkg::lc3b_beat;
    import cline_responder_pkg::state_t;
    import cline_responder_pkg::IDLE;
    import cline_responder_pkg::CAPTURE;
    import cline_responder_pkg::BEAT;
    import cline_responder_pkg::RESPOND;
#(
    parameter int LINE_WORDS = cline_responder_pkg::LINE_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          l2_read,
    input  logic          l2_write,
    input  lc3b_word      l2_address,
    input  lc3b_cacheline l2_wdata,
    output lc3b_cacheline l2_rdata,
    output logic          l2_resp,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    input  lc3b_word      mem_rdata,
    input  logic          mem_resp
);

    state_t        state;
    state_t        next_state;
    logic          op_read;     // latched operation, governs until RESPOND
    logic [11:0]   line_addr;   // line number; byte offset is always zero
    lc3b_beat      cnt;
    logic          request;
    logic          last_beat;
    logic          beat_done;
    lc3b_cacheline rbuf;
    lc3b_cacheline wbuf;
    logic          unused_addr_bits;

    // Simultaneous read and write is not a request.
    assign request   = l2_read ^ l2_write;
    assign last_beat = (cnt == lc3b_beat'(LINE_WORDS - 1));
    assign beat_done = (state == BEAT) && mem_resp;

    // Offset within the line is discarded.
    assign unused_addr_bits = ^l2_address[3:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (request) next_state = CAPTURE;
            CAPTURE: next_state = BEAT;
            BEAT:    if (mem_resp && last_beat) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode only from state and registers, never from mem_resp or
    // the l2_* inputs, so the memory side sees no combinational loop back.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        l2_resp     = 1'b0;
        unique case (state)
            BEAT: begin
                mem_read    = op_read;
                mem_write   = !op_read;
                mem_address = {line_addr, cnt, 1'b0};
                if (!op_read) begin
                    mem_wdata = wbuf[{cnt, 4'b0000} +: 16];
                end
            end
            RESPOND: l2_resp = 1'b1;
            default: ;
        endcase
    end

    // Operation, line address and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_read   <= 1'b0;
            line_addr <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: if (request) op_read <= l2_read;
                CAPTURE: begin
                    // Address lags the request by one cycle on the L1 side.
                    line_addr <= l2_address[15:4];
                    cnt       <= '0;
                end
                BEAT: if (mem_resp && !last_beat) cnt <= cnt + 3'd1;
                default: ;
            endcase
        end
    end

    // Read line assembled one word per completed beat.
    cline_beat_buffer u_rbuf (
        .clk      (clk),
        .rst      (rst),
        .line_we  (1'b0),
        .line_in  ('0),
        .word_we  (beat_done && op_read),
        .word_sel (cnt),
        .word_in  (mem_rdata),
        .line_out (rbuf)
    );

    // Write line captured whole, alongside the address.
    cline_beat_buffer u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .line_we  ((state == CAPTURE) && !op_read),
        .line_in  (l2_wdata),
        .word_we  (1'b0),
        .word_sel (cnt),
        .word_in  ('0),
        .line_out (wbuf)
    );

    assign l2_rdata = rbuf;

endmodule

// File: doc/cline_responder.md
# cline_responder

Responder end of the L1↔L2 line interface. Accepts one 128-bit cacheline read or write request from the L1 cache controller and services it as eight 16-bit word beats on a narrow memory bus. It returns a single-cycle `l2_resp` with the assembled line on reads. It sits between the L1 cache and word-wide physical memory.

## Interface
- `LINE_WORDS`, default 8: words per line. Fixed at 8 for `lc3b_cacheline`; it sizes the beat counter.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `l2_read`  in  1: line read request from L1, held until `l2_resp`.
- `l2_write`  in  1: line write request from L1, held until `l2_resp`.
- `l2_address`  in  16 (`lc3b_word`): line address. Registered at the L1 side, so it is valid one cycle after the request first rises.
- `l2_wdata`  in  128 (`lc3b_cacheline`): write line. Same one-cycle lag as `l2_address`.
- `l2_rdata`  out  128: assembled read line.
- `l2_resp`  out  1: transaction complete. Single-cycle pulse.
- `mem_read`  out  1: word read strobe.
- `mem_write`  out  1: word write strobe.
- `mem_address`  out  16: word address, always even.
- `mem_wdata`  out  16: write word.
- `mem_rdata`  in  16: read word. Valid when `mem_resp` is high.
- `mem_resp`  in  1: beat complete. May be high in the same cycle the strobe rises.

## Operation
- State register `state` has four states: IDLE, CAPTURE, BEAT, RESPOND.
- **IDLE:**
  - A request is `l2_read ^ l2_write`. If both or neither are high, stay in IDLE and drive nothing.
  - On a request, latch the operation (read/write) and go to CAPTURE.
- **CAPTURE:**
  - Latch `line_addr = {l2_address[15:4], 4'b0}` and, for writes, `wbuf = l2_wdata`.
  - Clear `cnt` to 0, then go to BEAT.
- **BEAT:**
  - Drive `mem_address = {line_addr[15:4], cnt[2:0], 1'b0}`.
  - Assert `mem_read` or `mem_write` according to the latched operation.
  - For writes, drive `mem_wdata = wbuf[16*cnt +: 16]`.
  - On `mem_resp`:
    - Reads store `mem_rdata` into `rbuf[16*cnt +: 16]`.
    - If `cnt == LINE_WORDS-1`, go to RESPOND. Otherwise increment `cnt`.
  - Without `mem_resp`, hold every output and `cnt` unchanged.
- **RESPOND:**
  - Assert `l2_resp` for exactly one cycle, then go to IDLE.
  - `l2_rdata = rbuf`. It stays stable until the next read's first beat overwrites word 0.
- Word order within a line is ascending: word 0 is at byte offset 0, word 7 at byte offset 14.
- Write transactions leave `rbuf` untouched.
- L1 drops its request combinationally on `l2_resp`, so the request is already low in the IDLE cycle after RESPOND.
  - A write-back immediately followed by a fill (`l2_write` falling, `l2_read` rising) is accepted in that IDLE cycle.
- Request changes while not in IDLE are ignored. The latched operation governs until RESPOND.

## Timing
- **Reset values:**
  - `state` = IDLE, `cnt` = 0.
  - `rbuf`, `wbuf`, `line_addr` = 0.
  - `l2_resp` = 0, `l2_rdata` = 0.
  - `mem_read` = 0, `mem_write` = 0, `mem_address` = 0, `mem_wdata` = 0.
- **Reset mid-transaction:**
  - Return to IDLE on the next edge and drop the strobes in that cycle.
  - No `l2_resp` is issued. A pending request is re-accepted after reset deasserts.
- **Output decoding:** strobes, `mem_address`, `mem_wdata` and `l2_resp` decode from the state and registers only. None of them depends combinationally on `mem_resp` or the `l2_*` inputs.
- **Strobe behaviour:** strobes stay continuously high across all 8 beats. The address advances in the cycle after each `mem_resp`.
- **Latency:**
  - With zero-wait memory (`mem_resp` always high in BEAT), `l2_resp` is high 10 cycles after the request's first cycle (IDLE 1, CAPTURE 1, BEAT 8, then the RESPOND cycle).
  - Each memory wait cycle adds exactly one cycle.
- **Boundaries:**
  - Address `0xFFF0` covers words `0xFFF0`–`0xFFFE`. There is no wrap into the next line.
  - `l2_address[3:0]` is ignored.

## Structure
- The `lc3b_types` package gains:
  - `localparam LINE_WORDS = 8`.
  - `typedef logic [2:0] lc3b_beat`.
- It reuses the existing `lc3b_word` and `lc3b_cacheline`.
- One sub-module is natural: `cline_beat_buffer`, a 128-bit register with per-word load enable and a word select. It is instantiated twice, for `rbuf` and `wbuf`.
  - `rbuf` loads one word per `mem_resp`.
  - `wbuf` loads the full line in CAPTURE.
- The FSM and counter live in `cline_responder`.

## Test plan
- **Read, zero-wait:** `l2_read` with `l2_address = 0x1234`.
  - Beats hit `0x1230`, `0x1232` … `0x123E`, with memory returning `0xA000+i`.
  - `l2_resp` is high at cycle 10 with `l2_rdata = 0xA007_A006_…_A000`.
- **Write, wait states:** `l2_write` with address `0x0040` and `l2_wdata = 0x0007_0006_…_0000`; memory inserts 2 wait cycles per beat.
  - `mem_wdata` equals `i` at address `0x0040+2i`, held through each wait.
  - `l2_resp` arrives at cycle 26.
- **Write-back then fill:** `l2_write` drops and `l2_read` rises in the IDLE cycle after `l2_resp`.
  - The read is accepted in that IDLE cycle.
  - Exactly one `l2_resp` per transaction, and the rdata is correct.
- **Illegal request:** `l2_read` and `l2_write` both high for 5 cycles.
  - No strobe, no `l2_resp`, state remains IDLE.
- **Reset mid-beat:** assert `rst` in beat 4 of a read.
  - Next cycle the strobes are 0, `l2_rdata` is 0 and no `l2_resp` is issued.
  - After release, the held request completes normally.
- **Top-of-memory:** read at `0xFFF7`.
  - Beats cover `0xFFF0`–`0xFFFE` only.
  - `mem_address` is never odd and never wraps to `0x0000`.
